// File: rtl/sfq_pulse_logger.sv
// ============================================================================
// sfq_pulse_logger
// ----------------------------------------------------------------------------
// Capture stage for the toggle-encoded output of the DSFQ AND cell. Every
// level transition on q_in is one SFQ pulse. The line is synchronised and
// edge-detected, each detected pulse is stamped with a free-running cycle
// counter, and the stamps are buffered in a FIFO that is read out over a
// valid/ready port. Pulse and overflow statistics are kept alongside.
//
// Parameters:
//   TS_W   timestamp counter width (wraps modulo 2^TS_W)
//   DEPTH  FIFO entries, power of two, >= 2
//   CNT_W  width of the saturating statistics counters
//
// Ports:
//   clk        in   single clock, all state on the rising edge
//   rst        in   asynchronous active-high reset
//   q_in       in   toggle-encoded pulse line, asynchronous to clk
//   out_ready  in   consumer accepts the head entry
//   out_valid  out  FIFO non-empty (registered)
//   out_ts     out  head-entry timestamp, holds last-read value when empty
//   pulse_cnt  out  detected pulses, saturating, dropped pulses included
//   ovf        out  sticky, set when any pulse is dropped
//   drop_cnt   out  dropped pulses, saturating
//
// Build option:
//   SFQ_LOG_DROP_CNT_EN  when defined, drop_cnt is a live saturating counter;
//                        otherwise the counter is omitted and drop_cnt is 0.
// ============================================================================
module sfq_pulse_logger #(
   parameter int TS_W  = 16,
   parameter int DEPTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             q_in,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [TS_W-1:0]  out_ts,
   output logic [CNT_W-1:0] pulse_cnt,
   output logic             ovf,
   output logic [CNT_W-1:0] drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic {
      ARM,
      RUN
   } state_e;

   // Synchroniser and edge-detect registers
   logic             syncS1_q;
   logic             syncS2_q;
   logic             prev_q;

   // Arming FSM
   state_e           state_q;
   logic [1:0]       armCnt_q;

   // Free-running timestamp
   logic [TS_W-1:0]  ts_q;

   // FIFO storage and pointers (extra MSB separates full from empty)
   logic [TS_W-1:0]  mem_q [DEPTH];
   logic [PW-1:0]    wrPtr_q;
   logic [PW-1:0]    wrPtr_d;
   logic [PW-1:0]    rdPtr_q;
   logic [PW-1:0]    rdPtr_d;

   // Registered outputs
   logic             outValid_q;
   logic             outValid_d;
   logic [TS_W-1:0]  outTs_q;
   logic [TS_W-1:0]  outTs_d;
   logic [CNT_W-1:0] pulseCnt_q;
   logic             ovf_q;

   // Per-cycle control
   logic             det;
   logic             pushReq;
   logic             fifoFull;
   logic             pop;
   logic             push;
   logic             drop;

   // Two-flop synchroniser followed by a delayed copy. A change between s2
   // and prev means exactly one toggle crossed the synchroniser this cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         syncS1_q <= 1'b0;
         syncS2_q <= 1'b0;
         prev_q   <= 1'b0;
      end else begin
         syncS1_q <= q_in;
         syncS2_q <= syncS1_q;
         prev_q   <= syncS2_q;
      end
   end

   // Arming FSM. The counter walks 0,1,2 and the third edge after reset
   // release moves to RUN; this masks the spurious transition seen when q_in
   // is already high at release. RUN is only left through reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ARM;
         armCnt_q <= 2'd0;
      end else begin
         case (state_q)
            ARM: begin
               if (armCnt_q == 2'd2) begin
                  state_q <= RUN;
               end else begin
                  armCnt_q <= armCnt_q + 2'd1;
               end
            end
            RUN: begin
               state_q <= RUN;
            end
            default: begin
               state_q  <= ARM;
               armCnt_q <= 2'd0;
            end
         endcase
      end
   end

   // Timestamp counter runs from reset, including while arming, and wraps
   // silently.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_q + TS_W'(1);
      end
   end

   // Detection, FIFO status and the push/pop/drop decision. A pop frees a
   // slot in the same cycle, so a push into a full FIFO is accepted when the
   // consumer reads at the same edge.
   always_comb begin
      det      = syncS2_q ^ prev_q;
      pushReq  = det && (state_q == RUN);
      fifoFull = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                 (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
      pop      = outValid_q && out_ready;
      push     = pushReq && (!fifoFull || pop);
      drop     = pushReq && fifoFull && !pop;
   end

   // Next pointers and next registered head. There is no bypass, so the
   // outputs always describe the FIFO contents after the edge. When the new
   // head slot is the one being written this cycle, its value is the current
   // timestamp rather than the stale memory contents. When the FIFO ends up
   // empty, out_ts keeps the last value it showed.
   always_comb begin
      wrPtr_d    = wrPtr_q + (push ? PW'(1) : PW'(0));
      rdPtr_d    = rdPtr_q + (pop  ? PW'(1) : PW'(0));
      outValid_d = (wrPtr_d != rdPtr_d);
      outTs_d    = outTs_q;
      if (outValid_d) begin
         if (push && (wrPtr_q[AW-1:0] == rdPtr_d[AW-1:0])) begin
            outTs_d = ts_q;
         end else begin
            outTs_d = mem_q[rdPtr_d[AW-1:0]];
         end
      end
   end

   // FIFO storage carries no reset: contents are only observed through the
   // pointers, which are cleared.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wrPtr_q[AW-1:0]] <= ts_q;
      end
   end

   // Pointers and the registered read port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         outValid_q <= 1'b0;
         outTs_q    <= '0;
      end else begin
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         outValid_q <= outValid_d;
         outTs_q    <= outTs_d;
      end
   end

   // Statistics: every detected pulse in RUN counts, whether stored or not.
   // The overflow flag is sticky until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pulseCnt_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         if (pushReq && (pulseCnt_q != {CNT_W{1'b1}})) begin
            pulseCnt_q <= pulseCnt_q + CNT_W'(1);
         end
         if (drop) begin
            ovf_q <= 1'b1;
         end
      end
   end

`ifdef SFQ_LOG_DROP_CNT_EN
   logic [CNT_W-1:0] dropCnt_q;

   // Saturating count of pulses lost to a full FIFO
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dropCnt_q <= '0;
      end else if (drop && (dropCnt_q != {CNT_W{1'b1}})) begin
         dropCnt_q <= dropCnt_q + CNT_W'(1);
      end
   end

   assign drop_cnt = dropCnt_q;
`else
   assign drop_cnt = '0;
`endif

   assign out_valid = outValid_q;
   assign out_ts    = outTs_q;
   assign pulse_cnt = pulseCnt_q;
   assign ovf       = ovf_q;

endmodule

// File: doc/sfq_pulse_logger.md
# sfq_pulse_logger

Clocked capture stage that sits directly downstream of the DSFQ `AND` cell in the behavioural test harness. It consumes the cell's toggle-encoded output `q`, where each level transition represents one SFQ pulse. It synchronises and edge-detects that line, timestamps every pulse against a free-running cycle counter, and buffers the timestamps in a FIFO for readout over a valid/ready port. Pulse and overflow statistics are kept alongside.

## Interface
- `TS_W`, default 16: timestamp counter width; wraps modulo 2^TS_W.
- `DEPTH`, default 8: FIFO entries; power of two, ≥ 2.
- `CNT_W`, default 8: width of the saturating statistics counters.

Ports:
- `clk` in 1: single clock; all state on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `q_in` in 1: toggle-encoded pulse line from the `AND` output. Asynchronous to `clk`.
- `out_ready` in 1: consumer accepts the head entry.
- `out_valid` out 1: FIFO non-empty.
- `out_ts` out TS_W: head-entry timestamp. Holds the last-read value when `out_valid` is 0.
- `pulse_cnt` out CNT_W: number of detected pulses, saturating; dropped pulses included.
- `ovf` out 1: sticky; set when any pulse is dropped.
- `drop_cnt` out CNT_W: number of dropped pulses, saturating. See Configuration.

## Operation
- Synchroniser: `q_in` → `s1` → `s2`, followed by a `prev` register that loads `s2` every cycle. Detection is `det = s2 ^ prev`.
- FSM, two states:
  - ARM: a 2-bit counter runs from 0 to 2. `det` is masked. The FSM moves to RUN on the 3rd rising edge after reset release.
  - RUN: `det` is live.
  - The FSM leaves RUN only through reset.
- Timestamp counter `ts`:
  - Resets to 0 and increments on every edge, including during ARM.
  - Wraps from 2^TS_W−1 to 0 without a flag.
  - A detected pulse pushes the current `ts` value, as seen in the detection cycle.
- FIFO:
  - Write and read pointers are log2(DEPTH)+1 bits; the MSB distinguishes full from empty.
  - Full: the pointers differ only in the MSB.
  - Empty: the pointers are equal.
  - There is no bypass path; `out_valid` rises one edge after a push into an empty FIFO.
- Pop: occurs when `out_valid & out_ready` is high at the edge.
- Push when full:
  - Full, no pop in the same cycle → the pulse is dropped. `ovf` is set and `drop_cnt` increments.
  - Full, pop in the same cycle → the push is accepted; nothing is dropped.
  - Empty, push with `out_ready` high → push only. No pop occurs because `out_valid` was 0.
- `pulse_cnt` increments on every detected pulse in RUN and saturates at 2^CNT_W−1.
- Input rate limit: `q_in` toggles must be at least 2 `clk` periods apart.
  - Two toggles inside one sample window cancel and produce no pulse. This is accepted behaviour, not an error.

## Timing
- Reset values: `s1`, `s2`, `prev` = 0; FSM = ARM with counter 0; `ts` = 0; both FIFO pointers = 0.
- Output reset values: `out_valid` = 0, `out_ts` = 0, `pulse_cnt` = 0, `ovf` = 0, `drop_cnt` = 0.
- Arming: a `q_in` level of 1 at reset release does not produce a pulse.
- Latency: `q_in` toggles before edge k → `s1` at edge k, `s2` at k+1, `det` high during cycle k+1..k+2 → push at edge k+2.
  - `out_valid` is high after edge k+2 when the FIFO was empty.
  - The entry holds `ts` = k+1.
- `out_ts` and `out_valid` are registered; they change only on `clk` edges or reset.
- Reset mid-operation: asynchronous clear of all state. Buffered entries are lost and the FSM returns to ARM.
- `out_ready` may be held high constantly; the FIFO then drains at one entry per cycle.

## Configuration
- `SFQ_LOG_DROP_CNT_EN`:
  - Defined: `drop_cnt` is a live saturating counter of dropped pulses.
  - Undefined: the counter logic is omitted and `drop_cnt` is tied to 0.
  - `ovf` behaves identically in both cases.

## Test plan
- Arming: hold `q_in`=1 through reset, release, run 10 cycles → `out_valid`=0, `pulse_cnt`=0.
- Single pulse: after reset release, toggle `q_in` 0→1 just before edge 5, `out_ready`=1 → `out_valid` high for one cycle after edge 7, `out_ts`=6, `pulse_cnt`=1.
- Fill and overflow with `DEPTH`=8 and `out_ready`=0: 10 toggles spaced 3 cycles apart → 8 entries with increasing timestamps, `ovf`=1, `pulse_cnt`=10, `drop_cnt`=2 (0 with the macro undefined).
- Full with a simultaneous pop: FIFO full, pulse detected in the same cycle as `out_ready`=1 → no drop, `ovf` unchanged, occupancy stays 8.
- Timestamp wrap with `TS_W`=4: toggle before edge 15 → `out_ts`=0 (16 mod 16), entry still accepted.
- Reset mid-stream: 3 entries buffered, assert `rst` asynchronously between edges → `out_valid` falls immediately and all counters read 0; a toggle 1 cycle after release is not logged.
